// File: rtl/fsa_24bit.sv
// Sequential shift-and-add multiplier: unsigned 24b x 24b -> 48b product, one partial step per clock.
// Latency: Result valid on the 24th rising edge after the last edge with rst=1; holds until next rst.
// Backpressure: none; no handshake. rst loads operands and starts; consumers count 24 cycles.
//
// Ports:
//    clk           rising-edge clock
//    rst           synchronous active-high reset, doubles as load/start
//    Multiplicand  operand A, sampled only while rst=1
//    Multiplier    operand B, sampled only while rst=1
//    Result        registered 48-bit product, 0 until the calculation completes
//    Co            registered carry-out of the latest 25-bit accumulate
module fsa_24bit (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] Multiplicand,
   input  logic [23:0] Multiplier,
   output logic [47:0] Result,
   output logic        Co
);

   logic [23:0] a_q, a_d;
   logic [47:0] p_q, p_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic [47:0] result_q, result_d;
   logic        co_q, co_d;

   logic [23:0] addend;
   logic [24:0] sum;

   // Upper half of P accumulates; the 25th bit is kept as the carry so the
   // shifted-in value never loses a bit and the 48-bit product stays exact.
   always_comb begin
      addend   = p_q[0] ? a_q : 24'd0;
      sum      = {1'b0, p_q[47:24]} + {1'b0, addend};

      a_d      = a_q;
      p_d      = p_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      result_d = result_q;
      co_d     = co_q;

      if (busy_q) begin
         p_d   = {sum, p_q[23:1]};
         co_d  = sum[24];
         cnt_d = cnt_q + 5'd1;
         // Last iteration publishes the freshly shifted value, not the stale one.
         if (cnt_q == 5'd23) begin
            result_d = {sum, p_q[23:1]};
            busy_d   = 1'b0;
         end
      end
   end

   // rst has priority over everything, including the completion edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= Multiplicand;
         p_q      <= {24'd0, Multiplier};
         cnt_q    <= 5'd0;
         busy_q   <= 1'b1;
         result_q <= 48'd0;
         co_q     <= 1'b0;
      end else begin
         a_q      <= a_d;
         p_q      <= p_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         result_q <= result_d;
         co_q     <= co_d;
      end
   end

   assign Result = result_q;
   assign Co     = co_q;

endmodule

// File: tb/tb_fsa_24bit.sv
// Directed bench for fsa_24bit: hand-computed products, latency, abort and hold behaviour.
// Latency: checks at edge 23 (still 0) and edge 24 (product) after each load.
// Backpressure: n/a; stimulus is a linear sequence of directed steps.
module tb_fsa_24bit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [23:0] mcand = 24'd0;
   logic [23:0] mplier = 24'd0;
   logic [47:0] result;
   logic        co;

   int n_chk  = 0;
   int n_fail = 0;

   fsa_24bit dut (
      .clk          (clk),
      .rst          (rst),
      .Multiplicand (mcand),
      .Multiplier   (mplier),
      .Result       (result),
      .Co           (co)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle away from it before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Edge 0: rst sampled with the operands; rst released afterwards.
   task automatic load(input logic [23:0] a, input logic [23:0] b);
      rst    = 1'b1;
      mcand  = a;
      mplier = b;
      step();
      rst    = 1'b0;
   endtask

   initial begin
      logic seen_co;

      // Reset state
      load(24'd3, 24'd5);
      chk("reset_result", result, 48'd0);
      chk("reset_co", {47'd0, co}, 48'd0);

      // Basic product 3*5: 0 through edge 23, 15 at edge 24, held 50 cycles
      steps(22);
      chk("basic_e22", result, 48'd0);
      step();
      chk("basic_e23", result, 48'd0);
      step();
      chk("basic_e24", result, 48'd15);
      chk("basic_co", {47'd0, co}, 48'd0);
      for (int i = 0; i < 50; i++) begin
         mcand  = 24'($urandom);
         mplier = 24'($urandom);
         step();
         chk("basic_hold", result, 48'd15);
      end

      // Max operands; Co must pulse at least once
      load(24'hFFFFFF, 24'hFFFFFF);
      seen_co = 1'b0;
      for (int i = 1; i <= 23; i++) begin
         step();
         if (co === 1'b1) seen_co = 1'b1;
      end
      chk("max_e23", result, 48'd0);
      step();
      if (co === 1'b1) seen_co = 1'b1;
      chk("max_e24", result, 48'hFFFFFE000001);
      chk("max_co_pulse", {47'd0, seen_co}, 48'd1);

      // Zero multiplier: Co stays 0 every iteration
      load(24'h123456, 24'd0);
      for (int i = 1; i <= 24; i++) begin
         step();
         chk("zeroB_co", {47'd0, co}, 48'd0);
      end
      chk("zeroB_result", result, 48'd0);

      // Zero multiplicand
      load(24'd0, 24'hABCDEF);
      for (int i = 1; i <= 24; i++) begin
         step();
         chk("zeroA_co", {47'd0, co}, 48'd0);
      end
      chk("zeroA_result", result, 48'd0);

      // Operand change while busy is ignored
      load(24'd1000, 24'd2000);
      mcand  = 24'hFFFFFF;
      mplier = 24'hFFFFFF;
      steps(23);
      chk("busychg_e23", result, 48'd0);
      step();
      chk("busychg_e24", result, 48'd2000000);

      // Reset mid-operation at edge 10
      load(24'd7, 24'd9);
      steps(9);
      chk("abort_e9", result, 48'd0);
      load(24'd12, 24'd12);
      chk("abort_result", result, 48'd0);
      chk("abort_co", {47'd0, co}, 48'd0);
      steps(23);
      chk("abort_e23", result, 48'd0);
      step();
      chk("abort_e24", result, 48'd144);

      // Held reset for 5 cycles, operands changing; last pair multiplied
      rst = 1'b1;
      mcand = 24'd11;     mplier = 24'd13;     step();
      chk("held_r1", result, 48'd0);
      mcand = 24'd500;    mplier = 24'd7;      step();
      chk("held_r2", result, 48'd0);
      mcand = 24'hFFFFFF; mplier = 24'h800000; step();
      chk("held_r3", result, 48'd0);
      mcand = 24'd42;     mplier = 24'd42;     step();
      chk("held_r4", result, 48'd0);
      mcand = 24'd100000; mplier = 24'd300;    step();
      chk("held_r5", result, 48'd0);
      rst = 1'b0;
      steps(23);
      chk("held_e23", result, 48'd0);
      step();
      chk("held_e24", result, 48'd30000000);

      // Reset on the completion edge wins over the product
      load(24'd6, 24'd7);
      steps(23);
      load(24'd2, 24'd3);
      chk("collide_result", result, 48'd0);
      steps(24);
      chk("collide_next", result, 48'd6);

      // Idle hold: result and Co stable with inputs wandering
      for (int i = 0; i < 10; i++) begin
         mcand  = 24'($urandom);
         mplier = 24'($urandom);
         step();
         chk("idle_hold", result, 48'd6);
         chk("idle_co", {47'd0, co}, 48'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
